// File: rtl/sequence_player_pkg.sv
// -----------------------------------------------------------------------------
// sequence_player_pkg
//
// Purpose : shared types and elaboration-time helpers for the Genius game
//           playback sequencer (sequence_player and its tick_gen sub-block).
//
// Contents:
//   player_state_t - state encoding of the playback FSM. It is deliberately
//                    separate from the game controller's own state type so
//                    that the two machines can evolve independently.
//   max3()         - largest of three integers, used to size the phase
//                    tick counter from the three period parameters.
//   tick_cnt_w()   - bit width needed to hold a tick count 0..max_val.
// -----------------------------------------------------------------------------
package sequence_player_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      WAIT_DATA = 3'd2,
      LED_ON    = 3'd3,
      LED_OFF   = 3'd4,
      DONE      = 3'd5
   } player_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Enough bits to represent every value 0..max_val inclusive.
   function automatic int tick_cnt_w(input int max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sequence_player_if.sv
// -----------------------------------------------------------------------------
// sequence_player_if
//
// Purpose : read port between the playback sequencer and the sequence memory.
//           The memory returns data one cycle after the read strobe.
//
// Signals :
//   mem_rd   - read strobe, one cycle per item fetched
//   mem_addr - read address (item index)
//   mem_data - read data, valid the cycle after mem_rd
//
// Modports:
//   master - the sequencer (drives mem_rd / mem_addr, receives mem_data)
//   slave  - the sequence memory
// -----------------------------------------------------------------------------
interface sequence_player_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 4
) ();

   logic                  mem_rd;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_data
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_data
   );

endinterface

// File: rtl/sequence_player_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Purpose : display time base. Emits a one-cycle tick every TICK_DIV clock
//           cycles, counted from the last cycle in which clear was high.
//           Holding clear keeps the divider parked at zero, so the first tick
//           after clear drops arrives exactly TICK_DIV cycles later.
//
// Ports   :
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   clear in  restart the divider (synchronous)
//   tick  out one-cycle pulse, high in the last cycle of each TICK_DIV period
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int             CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Not gated by clear: the parent derives clear from tick at the end of an
   // on-period, and gating here would close a combinational loop. Because
   // TICK_DIV >= 2, a parked divider (count 0) never reports a tick anyway.
   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sequence_player.sv
// -----------------------------------------------------------------------------
// sequence_player
//
// Purpose : paced playback of the stored colour sequence on the LED display.
//           One start request walks addresses 0..length-1: each item is read
//           from sequence memory, shown for an on-period chosen by speed,
//           followed by a blank gap. done pulses once after the last gap.
//
// Ports   :
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   start    in   playback request, only honoured while idle
//   length   in   number of items to play, captured with start
//   speed    in   0 = slow (ON_SLOW ticks), 1 = fast (ON_FAST ticks)
//   abort    in   cancel playback, overrides everything else
//   mem      --   sequence memory read port (master side)
//   led_out  out  registered LED drive (one-hot colour, 0 = blank)
//   busy     out  high whenever not idle
//   done     out  one-cycle pulse on completed playback
//
// Timing  : FETCH and WAIT_DATA take one cycle each; LED_ON lasts
//           on_ticks*TICK_DIV cycles and LED_OFF GAP_TICKS*TICK_DIV cycles,
//           so one item costs 2 + (on_ticks + GAP_TICKS)*TICK_DIV cycles.
// -----------------------------------------------------------------------------
module sequence_player
   import sequence_player_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int TICK_DIV   = 1000,
   parameter int ON_SLOW    = 8,
   parameter int ON_FAST    = 4,
   parameter int GAP_TICKS  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] length,
   input  logic                  speed,
   input  logic                  abort,
   sequence_player_if.master     mem,
   output logic [DATA_WIDTH-1:0] led_out,
   output logic                  busy,
   output logic                  done
);

   // Phase tick counter must hold the longest of the three periods.
   localparam int              PH_MAX = max3(ON_SLOW, ON_FAST, GAP_TICKS);
   localparam int              PH_W   = tick_cnt_w(PH_MAX);
   localparam logic [PH_W-1:0] ON_SLOW_T   = PH_W'(ON_SLOW);
   localparam logic [PH_W-1:0] ON_FAST_T   = PH_W'(ON_FAST);
   localparam logic [PH_W-1:0] GAP_LAST_T  = PH_W'(GAP_TICKS - 1);

   player_state_t         state_q;
   logic [ADDR_WIDTH-1:0] idx_q;        // item being played, also mem_addr
   logic [ADDR_WIDTH-1:0] len_q;        // length captured at start
   logic [PH_W-1:0]       on_ticks_q;   // on-period captured at start
   logic [PH_W-1:0]       ph_cnt_q;     // ticks elapsed in current phase
   logic                  mem_rd_q;
   logic [DATA_WIDTH-1:0] led_q;
   logic                  done_q;
   logic                  busy_q;

   logic tick;
   logic tick_clear;
   logic on_end;
   logic gap_end;
   logic last_item;

   // ------------------------------------------------------------------
   // Display time base
   // ------------------------------------------------------------------
   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (tick_clear),
      .tick  (tick)
   );

   // ------------------------------------------------------------------
   // Phase bookkeeping
   // ------------------------------------------------------------------
   always_comb begin
      on_end     = 1'b0;
      gap_end    = 1'b0;
      last_item  = 1'b0;
      tick_clear = 1'b1;

      on_end    = (state_q == LED_ON)  && tick && (ph_cnt_q == on_ticks_q - PH_W'(1));
      gap_end   = (state_q == LED_OFF) && tick && (ph_cnt_q == GAP_LAST_T);
      last_item = (idx_q == len_q - ADDR_WIDTH'(1));

      // The divider runs only inside the timed phases. Parking it elsewhere
      // (in particular during WAIT_DATA) makes LED_ON start from a fresh
      // count; the explicit restart at the end of LED_ON does the same for
      // LED_OFF, so every phase is exact regardless of history.
      tick_clear = !((state_q == LED_ON) || (state_q == LED_OFF)) || on_end;
   end

   // ------------------------------------------------------------------
   // Playback FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         len_q      <= '0;
         on_ticks_q <= '0;
         ph_cnt_q   <= '0;
         mem_rd_q   <= 1'b0;
         led_q      <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         // Strobes default low; the transitions below raise them for the
         // single cycle they belong to.
         mem_rd_q <= 1'b0;
         done_q   <= 1'b0;

         if (abort && (state_q != IDLE)) begin
            state_q  <= IDLE;
            led_q    <= '0;
            busy_q   <= 1'b0;
            ph_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start && !abort) begin
                     busy_q <= 1'b1;
                     if (length != '0) begin
                        state_q    <= FETCH;
                        len_q      <= length;
                        on_ticks_q <= speed ? ON_FAST_T : ON_SLOW_T;
                        idx_q      <= '0;
                        ph_cnt_q   <= '0;
                        mem_rd_q   <= 1'b1;
                     end else begin
                        // Empty sequence: report completion without reading.
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end

               FETCH: begin
                  state_q <= WAIT_DATA;
               end

               WAIT_DATA: begin
                  led_q    <= mem.mem_data;
                  ph_cnt_q <= '0;
                  state_q  <= LED_ON;
               end

               LED_ON: begin
                  if (on_end) begin
                     led_q    <= '0;
                     ph_cnt_q <= '0;
                     state_q  <= LED_OFF;
                  end else if (tick) begin
                     ph_cnt_q <= ph_cnt_q + PH_W'(1);
                  end
               end

               LED_OFF: begin
                  if (gap_end) begin
                     ph_cnt_q <= '0;
                     if (last_item) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        idx_q    <= idx_q + ADDR_WIDTH'(1);
                        mem_rd_q <= 1'b1;
                        state_q  <= FETCH;
                     end
                  end else if (tick) begin
                     ph_cnt_q <= ph_cnt_q + PH_W'(1);
                  end
               end

               DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end

               default: begin
                  state_q <= IDLE;
                  led_q   <= '0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem.mem_rd   = mem_rd_q;
   assign mem.mem_addr = idx_q;
   assign led_out      = led_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: doc/sequence_player.md
# sequence_player

Playback sequencer for the Genius game's LED display. On a single start request it walks the stored colour sequence from address 0 to length-1. For each item it reads sequence memory, lights the item's LED for a speed-dependent on-period, then blanks for a fixed gap. It pulses done at the end. It sits between the game controller (start/length/speed/abort) and the sequence memory plus LED drivers, and replaces free-running display of the sequence with paced, human-visible playback.

## Interface
- DATA_WIDTH, 4, width of one sequence item / LED vector (one-hot colour)
- ADDR_WIDTH, 5, sequence memory address width
- TICK_DIV, 1000, clk cycles per display tick (≥2)
- ON_SLOW, 8, on-period in ticks when speed=0 (≥1)
- ON_FAST, 4, on-period in ticks when speed=1 (≥1)
- GAP_TICKS, 2, blank period in ticks between items (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  playback request, sampled only in IDLE
- length  in  ADDR_WIDTH  number of items to play, sampled with start
- speed  in  1  0=slow, 1=fast, sampled with start
- abort  in  1  cancel playback, highest priority
- mem_rd  out  1  sequence memory read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd
- led_out  out  DATA_WIDTH  LED drive, registered
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completed playback

## Operation
- States: IDLE, FETCH, WAIT_DATA, LED_ON, LED_OFF, DONE.
- IDLE → FETCH when start && !abort && length≠0. Latch length, latch the on-period selected by speed, and clear idx to 0.
- IDLE → DONE when start && !abort && length==0. No memory read occurs.
- FETCH: mem_rd=1 and mem_addr=idx for exactly one cycle. Always → WAIT_DATA.
- WAIT_DATA: led_out ← mem_data at the end of the cycle. → LED_ON.
- LED_ON: led_out holds the item for on_ticks×TICK_DIV cycles. → LED_OFF.
- LED_OFF: led_out=0 for GAP_TICKS×TICK_DIV cycles.
  - If idx==length_q-1 → DONE.
  - Else idx increments and → FETCH.
- DONE: done=1 for one cycle. → IDLE.
- abort from any non-IDLE state → IDLE on the next edge. led_out is cleared, done is not pulsed, mem_rd drops.
- start while busy is ignored. Changes to length or speed while busy have no effect.
- mem_addr holds idx in all states. mem_rd is high only in FETCH.
- The tick counter is cleared on entry to LED_ON and LED_OFF, so phase durations are exact and independent of history.
- Reset values: state IDLE; mem_rd, done, busy, led_out all 0; mem_addr 0; idx 0.
- Reset asserted mid-playback returns to IDLE immediately (asynchronous) with all outputs at reset values.

## Timing
- start sampled at edge 0 → FETCH during cycle 1, WAIT_DATA cycle 2, LED_ON from cycle 3.
- Per item: 2 + (on_ticks+GAP_TICKS)×TICK_DIV cycles.
- done is high exactly length×(2+(on_ticks+GAP_TICKS)×TICK_DIV)+1 cycles after the start edge.
- length==0: done is high in cycle 1; busy is high in cycle 1 only.
- busy rises the cycle after start is accepted and falls the cycle after done.
- length wrap: idx is ADDR_WIDTH wide. length=2^ADDR_WIDTH-1 plays addresses 0..2^ADDR_WIDTH-2 with no wrap.

## Structure
- typedefs_pkg gains player_state_t, an enum of the six states, kept separate from state_t.
- Sub-module tick_gen (TICK_DIV parameter) has inputs clk, rst_n and clear, and outputs a one-cycle tick every TICK_DIV cycles after clear. sequence_player counts ticks against the phase target.
- Phase tick counter width is $clog2(max(ON_SLOW,ON_FAST,GAP_TICKS)+1).

## Test plan
Bench parameters: TICK_DIV=4, ON_SLOW=3, ON_FAST=1, GAP_TICKS=1. Memory is preloaded with 1,2,4,8 at addresses 0..3.
- Fast playback: start, length=3, speed=1 → mem_rd at addresses 0,1,2. led_out shows 1,2,4, each for 4 cycles with 4-cycle gaps. done is high at cycle 3×(2+8)+1=31.
- Slow playback: length=1, speed=0 → led_out=1 for 12 cycles, then 0 for 4. done at cycle 19. busy is high in cycles 1..19.
- length=0 → done is high in cycle 1, no mem_rd, led_out stays 0.
- abort during LED_ON of item 1 (length=3) → next cycle: IDLE, led_out=0, busy=0, no done pulse. A new start then plays from address 0.
- start re-asserted while busy, with length changed to 1 mid-run → ignored; playback of the original 3 items completes unchanged.
- rst_n pulsed low during LED_OFF → all outputs 0 asynchronously. The block stays IDLE after release until the next start.
